// File: rtl/input_frame_loader.sv
// Upstream feeder for the net core: gathers a valid/ready word stream into
// 7-word frames in a shadow buffer and presents each frame on registered buses.
module input_frame_loader #(
  parameter int WORD_W     = 32,
  parameter int RST_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [WORD_W-1:0] data_in_0,
  output logic [WORD_W-1:0] data_in_1,
  output logic [WORD_W-1:0] data_in_2,
  output logic [WORD_W-1:0] data_in_3,
  output logic [WORD_W-1:0] data_in_4,
  output logic [WORD_W-1:0] data_in_5,
  output logic [WORD_W-1:0] data_in_6,
  output logic              reset,
  output logic              in_rdy,
  input  logic              net_rdy,
  output logic [15:0]       frame_cnt,
  output logic              err
);

  localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NRST    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  logic [WORD_W-1:0] shadow_r [7];
  logic [WORD_W-1:0] data_r [7];
  logic [2:0]        idx_r;
  logic              shadow_full_r;
  logic              ready_en_r;
  logic              err_r;
  state_t            state_r;
  state_t            state_s;
  logic [3:0]        rst_cnt_r;
  logic [3:0]        rst_cnt_s;
  logic              copy_s;
  logic              ack_s;
  logic              reset_r;
  logic              in_rdy_r;
  logic [15:0]       frame_cnt_r;
  logic              xfer_s;

  // ready_en_r keeps s_ready low until the first edge after reset release
  assign s_ready   = ready_en_r & ~shadow_full_r;
  assign xfer_s    = s_valid & s_ready;
  assign data_in_0 = data_r[0];
  assign data_in_1 = data_r[1];
  assign data_in_2 = data_r[2];
  assign data_in_3 = data_r[3];
  assign data_in_4 = data_r[4];
  assign data_in_5 = data_r[5];
  assign data_in_6 = data_r[6];
  assign reset     = reset_r;
  assign in_rdy    = in_rdy_r;
  assign frame_cnt = frame_cnt_r;
  assign err       = err_r;

  // Collect side: word index, shadow buffer, full flag and sticky framing error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 7; i++) begin
        shadow_r[i] <= '0;
      end
      idx_r         <= 3'd0;
      shadow_full_r <= 1'b0;
      ready_en_r    <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (xfer_s) begin
        if (idx_r == 3'd6) begin
          idx_r <= 3'd0;
          if (s_last) begin
            shadow_r[6]   <= s_data;
            shadow_full_r <= 1'b1;
          end else begin
            err_r <= 1'b1;
          end
        end else if (s_last) begin
          idx_r <= 3'd0;
          err_r <= 1'b1;
        end else begin
          shadow_r[idx_r] <= s_data;
          idx_r           <= idx_r + 3'd1;
        end
      end else if (copy_s) begin
        shadow_full_r <= 1'b0;
      end
    end
  end

  // Present FSM next-state and control decode
  always_comb begin
    state_s   = state_r;
    rst_cnt_s = rst_cnt_r;
    copy_s    = 1'b0;
    ack_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (shadow_full_r) begin
          copy_s    = 1'b1;
          rst_cnt_s = RST_LOAD;
          state_s   = NRST;
        end else begin
          state_s = IDLE;
        end
      end
      NRST: begin
        if (rst_cnt_r <= 4'd1) begin
          rst_cnt_s = 4'd0;
          state_s   = PRESENT;
        end else begin
          rst_cnt_s = rst_cnt_r - 4'd1;
        end
      end
      PRESENT: begin
        if (net_rdy) begin
          ack_s   = 1'b1;
          state_s = DONE;
        end else begin
          state_s = PRESENT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, registered outputs decoded from next state, frame copy and count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      rst_cnt_r   <= 4'd0;
      reset_r     <= 1'b0;
      in_rdy_r    <= 1'b0;
      frame_cnt_r <= 16'd0;
      for (int i = 0; i < 7; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      state_r   <= state_s;
      rst_cnt_r <= rst_cnt_s;
      reset_r   <= (state_s == NRST);
      in_rdy_r  <= (state_s == PRESENT);
      if (copy_s) begin
        data_r <= shadow_r;
      end
      if (ack_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_input_frame_loader.sv
// Self-checking bench for input_frame_loader: vector table, directed corner
// sequences, and randomized traffic against a frame-level reference model.
module tb_input_frame_loader;

  localparam int W = 32;
  typedef logic [7*W-1:0] frame_t;

  typedef struct {
    logic        v;
    logic [W-1:0] d;
    logic        last;
    logic        nr;
    logic        e_srdy;
    logic        e_rst;
    logic        e_inrdy;
    logic [15:0] e_cnt;
    logic [W-1:0] e_d0;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_last;
  logic         net_rdy;

  logic         s_ready1, reset1, in_rdy1, err1;
  logic [15:0]  cnt1;
  logic [W-1:0] d1 [7];
  logic         s_ready4, reset4, in_rdy4, err4;
  logic [15:0]  cnt4;
  logic [W-1:0] d4 [7];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model state for the random phase
  logic [W-1:0] cur [$];
  frame_t       exp_q [$];
  logic         exp_err;
  int           n_model;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_frame_loader #(.WORD_W(W), .RST_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready1),
    .data_in_0(d1[0]), .data_in_1(d1[1]), .data_in_2(d1[2]), .data_in_3(d1[3]),
    .data_in_4(d1[4]), .data_in_5(d1[5]), .data_in_6(d1[6]),
    .reset(reset1), .in_rdy(in_rdy1), .net_rdy(net_rdy),
    .frame_cnt(cnt1), .err(err1)
  );

  input_frame_loader #(.WORD_W(W), .RST_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready4),
    .data_in_0(d4[0]), .data_in_1(d4[1]), .data_in_2(d4[2]), .data_in_3(d4[3]),
    .data_in_4(d4[4]), .data_in_5(d4[5]), .data_in_6(d4[6]),
    .reset(reset4), .in_rdy(in_rdy4), .net_rdy(net_rdy),
    .frame_cnt(cnt4), .err(err4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic last,
                              input logic nr, input logic srdy, input logic rst,
                              input logic inrdy, input logic [15:0] cnt, input logic [W-1:0] d0);
    vec_t r;
    r.v = v; r.d = d; r.last = last; r.nr = nr;
    r.e_srdy = srdy; r.e_rst = rst; r.e_inrdy = inrdy; r.e_cnt = cnt; r.e_d0 = d0;
    return r;
  endfunction

  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; net_rdy = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic send_word(input int sel, input logic [W-1:0] d, input logic l);
    logic rd;
    int   n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    do begin
      rd = (sel == 4) ? s_ready4 : s_ready1;
      @(posedge clk); #1;
      n++;
    end while (!rd && n < 200);
    check("send_handshake", rd, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_seq(input int sel, input logic [W-1:0] first, input int len, input logic with_last);
    for (int k = 0; k < len; k++) begin
      send_word(sel, first + W'(k), with_last && (k == len - 1));
    end
  endtask

  task automatic wait_inrdy1();
    int n;
    n = 0;
    while (!in_rdy1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_in_rdy", in_rdy1, 1'b1);
  endtask

  task automatic ack1();
    net_rdy = 1'b1;
    @(posedge clk); #1;
    net_rdy = 1'b0;
  endtask

  task automatic check_frame1(input string name, input logic [W-1:0] first);
    for (int k = 0; k < 7; k++) begin
      check(name, d1[k], first + W'(k));
    end
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic l);
    frame_t f;
    if (cur.size() == 6) begin
      if (l) begin
        for (int k = 0; k < 6; k++) f[k*W +: W] = cur[k];
        f[6*W +: W] = d;
        exp_q.push_back(f);
        n_model++;
      end else begin
        exp_err = 1'b1;
      end
      cur.delete();
    end else if (l) begin
      exp_err = 1'b1;
      cur.delete();
    end else begin
      cur.push_back(d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [14];
    logic rt [128];
    logic it [128];
    int   rr [$];
    int   rf [$];
    int   ir [$];
    int   ifl [$];
    int   base, last_a, last_b, exp_b;
    logic [W-1:0] sw_d [$];
    logic         sw_l [$];
    logic hs, ack, prev_rdy;
    int   rst_run;
    frame_t f;

    // ---------------- single frame, table driven ----------------
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; net_rdy = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_s_ready", s_ready1, 1'b0);
    check("rst_reset", reset1, 1'b0);
    check("rst_in_rdy", in_rdy1, 1'b0);
    check("rst_frame_cnt", cnt1, 16'd0);
    check("rst_err", err1, 1'b0);
    check("rst_data0", d1[0], '0);
    reset_n = 1'b1;

    tbl[0] = mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 0);
    for (int k = 1; k <= 6; k++) tbl[k] = mk(1'b1, W'(k), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 0);
    tbl[7]  = mk(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0);
    tbl[8]  = mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1);
    tbl[9]  = mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 1);
    tbl[10] = mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 1);
    tbl[11] = mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 1);
    tbl[12] = mk(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 1);
    tbl[13] = mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 1);

    for (int i = 0; i < 14; i++) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].last; net_rdy = tbl[i].nr;
      @(posedge clk); #1;
      check("tbl_s_ready", s_ready1, tbl[i].e_srdy);
      check("tbl_reset", reset1, tbl[i].e_rst);
      check("tbl_in_rdy", in_rdy1, tbl[i].e_inrdy);
      check("tbl_frame_cnt", cnt1, tbl[i].e_cnt);
      check("tbl_data0", d1[0], tbl[i].e_d0);
    end
    check_frame1("single_frame_word", 1);
    check("single_err", err1, 1'b0);

    // ---------------- back-to-back frames ----------------
    do_reset();
    send_seq(1, 10, 7, 1'b1);
    send_seq(1, 20, 7, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_in_rdy_hold", in_rdy1, 1'b1);
    check("b2b_s_ready_full", s_ready1, 1'b0);
    check_frame1("b2b_a_word", 10);
    ack1();
    check("b2b_done_in_rdy", in_rdy1, 1'b0);
    check("b2b_done_cnt", cnt1, 16'd1);
    check("b2b_done_s_ready", s_ready1, 1'b0);
    @(posedge clk); #1;
    check("b2b_idle_data0", d1[0], 10);
    check("b2b_idle_s_ready", s_ready1, 1'b0);
    @(posedge clk); #1;
    check_frame1("b2b_b_word", 20);
    check("b2b_copy_reset", reset1, 1'b1);
    check("b2b_copy_s_ready", s_ready1, 1'b1);
    wait_inrdy1();
    ack1();
    check("b2b_cnt", cnt1, 16'd2);

    // ---------------- short frame ----------------
    do_reset();
    send_seq(1, 51, 3, 1'b1);
    check("short_err", err1, 1'b1);
    check("short_s_ready", s_ready1, 1'b1);
    send_seq(1, 1, 7, 1'b1);
    wait_inrdy1();
    check_frame1("short_good_word", 1);
    ack1();
    check("short_cnt", cnt1, 16'd1);
    repeat (5) @(posedge clk);
    #1;
    check("short_no_extra_in_rdy", in_rdy1, 1'b0);
    check("short_no_extra_reset", reset1, 1'b0);

    // ---------------- long frame ----------------
    do_reset();
    send_seq(1, 100, 7, 1'b0);
    check("long_err", err1, 1'b1);
    send_seq(1, 1, 7, 1'b1);
    wait_inrdy1();
    check_frame1("long_good_word", 1);
    ack1();
    check("long_cnt", cnt1, 16'd1);

    // ---------------- reset mid-PRESENT with a partial frame pending ----------------
    send_seq(1, 31, 7, 1'b1);
    wait_inrdy1();
    send_seq(1, 90, 3, 1'b0);
    check("mid_in_rdy_before", in_rdy1, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_in_rdy", in_rdy1, 1'b0);
    check("mid_reset", reset1, 1'b0);
    check("mid_data0", d1[0], '0);
    check("mid_data6", d1[6], '0);
    check("mid_cnt", cnt1, 16'd0);
    check("mid_err", err1, 1'b0);
    check("mid_s_ready_in_reset", s_ready1, 1'b0);
    #1 reset_n = 1'b1;
    #1;
    check("mid_s_ready_release", s_ready1, 1'b0);
    @(posedge clk); #1;
    check("mid_s_ready_after_edge", s_ready1, 1'b1);
    send_seq(1, 1, 7, 1'b1);
    wait_inrdy1();
    check_frame1("mid_clean_word", 1);
    check("mid_clean_err", err1, 1'b0);

    // ---------------- RST_CYCLES = 4, net_rdy held high ----------------
    do_reset();
    for (int i = 0; i < 128; i++) begin rt[i] = 1'b0; it[i] = 1'b0; end
    base = cyc;
    last_a = 0; last_b = 0;
    net_rdy = 1'b1;
    fork
      begin
        send_seq(4, 40, 7, 1'b1);
        last_a = cyc - base;
        send_seq(4, 50, 7, 1'b1);
        last_b = cyc - base;
      end
      begin
        for (int c = 0; c < 70; c++) begin
          @(posedge clk); #1;
          if (cyc - base < 128) begin
            rt[cyc - base] = reset4;
            it[cyc - base] = in_rdy4;
          end
        end
      end
    join
    net_rdy = 1'b0;
    for (int i = 1; i < 128; i++) begin
      if (rt[i] && !rt[i-1]) rr.push_back(i);
      if (!rt[i] && rt[i-1]) rf.push_back(i);
      if (it[i] && !it[i-1]) ir.push_back(i);
      if (!it[i] && it[i-1]) ifl.push_back(i);
    end
    check("r4_reset_pulses", rr.size(), 2);
    check("r4_in_rdy_pulses", ir.size(), 2);
    if (rr.size() == 2 && rf.size() == 2 && ir.size() == 2 && ifl.size() == 2) begin
      for (int k = 0; k < 2; k++) begin
        check("r4_reset_len", rf[k] - rr[k], 4);
        check("r4_in_rdy_len", ifl[k] - ir[k], 1);
        check("r4_in_rdy_after_reset", ir[k], rr[k] + 4);
      end
      check("r4_a_reset_start", rr[0], last_a + 1);
      exp_b = (last_b + 1 > ifl[0] + 2) ? last_b + 1 : ifl[0] + 2;
      check("r4_b_reset_start", rr[1], exp_b);
    end
    for (int k = 0; k < 7; k++) check("r4_b_word", d4[k], 50 + k);
    check("r4_cnt", cnt4, 16'd2);

    // ---------------- randomized traffic vs frame-level model ----------------
    do_reset();
    cur.delete(); exp_q.delete();
    exp_err = 1'b0; n_model = 0; rst_run = 0;
    for (int fr = 0; fr < 30; fr++) begin
      int len;
      len = ($urandom_range(0, 9) < 7) ? 7 : int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) begin
        sw_d.push_back(W'($urandom));
        sw_l.push_back(j == len - 1);
      end
    end
    for (int c = 0; c < 5000; c++) begin
      if (sw_d.size() > 0 && $urandom_range(0, 3) != 0) begin
        s_valid = 1'b1; s_data = sw_d[0]; s_last = sw_l[0];
      end else begin
        s_valid = 1'b0; s_last = 1'b0; s_data = W'($urandom);
      end
      net_rdy  = ($urandom_range(0, 2) == 0);
      hs       = s_valid && s_ready1;
      ack      = in_rdy1 && net_rdy;
      prev_rdy = in_rdy1;
      @(posedge clk); #1;
      if (hs) begin
        model_accept(sw_d[0], sw_l[0]);
        void'(sw_d.pop_front());
        void'(sw_l.pop_front());
      end
      if (in_rdy1 && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_frame", 1'b1, 1'b0);
        end else begin
          f = exp_q.pop_front();
          for (int k = 0; k < 7; k++) check("rand_word", d1[k], f[k*W +: W]);
        end
      end
      if (reset1) begin
        rst_run++;
      end else if (rst_run != 0) begin
        check("rand_reset_len", rst_run, 1);
        rst_run = 0;
      end
      if (ack) check("rand_done_in_rdy", in_rdy1, 1'b0);
      if (sw_d.size() == 0 && exp_q.size() == 0 && !in_rdy1 && !reset1) break;
    end
    s_valid = 1'b0; s_last = 1'b0; net_rdy = 1'b0;
    check("rand_stream_drained", sw_d.size(), 0);
    check("rand_frames_drained", exp_q.size(), 0);
    check("rand_frame_cnt", cnt1, 16'(n_model));
    check("rand_err", err1, exp_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
